// File: rtl/imu_frame_ctrl.sv
// Link supervisor and 2-entry frame buffer between the CSV frame parser and downstream consumers.
// Optional frame/drop statistics counters are built only when IMU_FRAME_CTRL_STATS_EN is defined.
module imu_frame_ctrl #(
   parameter int TIMEOUT_CYC = 5_000_000,
   parameter int ACQ_FRAMES  = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         frame_done,
   input  logic [120:0] frame_in,
   output logic [120:0] out_frame,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         link_up,
   output logic         link_lost,
   output logic [15:0]  frame_cnt,
   output logic [15:0]  drop_cnt
);

   localparam int IDLE_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam int ACQ_W  = $clog2(ACQ_FRAMES + 1);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);
   localparam logic [ACQ_W-1:0]  ACQ_TGT  = ACQ_W'(ACQ_FRAMES);

   localparam logic [1:0] ST_NO_LINK = 2'd0;
   localparam logic [1:0] ST_ACQUIRE = 2'd1;
   localparam logic [1:0] ST_LOCKED  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ACQ_W-1:0]  acq_q, acq_d, acq_inc;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              link_lost_q, link_lost_d;
   logic              timeout;
   logic              fwd;

   logic [120:0] head_q, head_d;
   logic [120:0] tail_q, tail_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         full;
   logic         pop;
   logic         push;

   assign acq_inc = acq_q + 1'b1;
   assign timeout = (idle_q == IDLE_MAX) && !frame_done;

   // A frame arriving together with the timeout cycle keeps the link alive.
   always_comb begin
      state_d     = state_q;
      acq_d       = acq_q;
      idle_d      = idle_q;
      link_lost_d = 1'b0;
      fwd         = 1'b0;
      if (!en) begin
         state_d     = ST_NO_LINK;
         acq_d       = '0;
         idle_d      = '0;
         link_lost_d = (state_q == ST_LOCKED);
      end else begin
         if (frame_done) begin
            idle_d = '0;
         end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
         end
         case (state_q)
            ST_NO_LINK: begin
               if (frame_done) begin
                  if (ACQ_FRAMES == 1) begin
                     state_d = ST_LOCKED;
                     fwd     = 1'b1;
                  end else begin
                     state_d = ST_ACQUIRE;
                     acq_d   = ACQ_W'(1);
                  end
               end
            end
            ST_ACQUIRE: begin
               if (frame_done) begin
                  if (acq_inc == ACQ_TGT) begin
                     state_d = ST_LOCKED;
                     acq_d   = '0;
                     fwd     = 1'b1;
                  end else begin
                     acq_d = acq_inc;
                  end
               end else if (timeout) begin
                  state_d = ST_NO_LINK;
                  acq_d   = '0;
               end
            end
            ST_LOCKED: begin
               if (frame_done) begin
                  fwd = 1'b1;
               end else if (timeout) begin
                  state_d     = ST_NO_LINK;
                  link_lost_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_NO_LINK;
               acq_d   = '0;
            end
         endcase
      end
   end

   assign out_valid = (cnt_q != 2'd0);
   assign out_frame = head_q;
   assign pop       = out_valid && out_ready;
   assign full      = (cnt_q == 2'd2);
   assign push      = fwd && (!full || pop);

   // Head register always presents the oldest entry; tail holds the second one.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               head_d = frame_in;
               cnt_d  = 2'd1;
            end else begin
               tail_d = frame_in;
               cnt_d  = 2'd2;
            end
         end
         2'b01: begin
            if (cnt_q == 2'd2) begin
               head_d = tail_q;
            end
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd2) begin
               head_d = tail_q;
               tail_d = frame_in;
            end else begin
               head_d = frame_in;
            end
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_NO_LINK;
         acq_q       <= '0;
         idle_q      <= '0;
         link_lost_q <= 1'b0;
         head_q      <= '0;
         tail_q      <= '0;
         cnt_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         acq_q       <= acq_d;
         idle_q      <= idle_d;
         link_lost_q <= link_lost_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         cnt_q       <= cnt_d;
      end
   end

   assign link_up   = (state_q == ST_LOCKED);
   assign link_lost = link_lost_q;

`ifdef IMU_FRAME_CTRL_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic        drop;

   assign drop = fwd && full && !pop;

   // Both counters saturate rather than wrap.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      if (push && (frame_cnt_q != 16'hFFFF)) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`else
   assign frame_cnt = '0;
   assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_imu_frame_ctrl.sv
// Directed self-checking bench for imu_frame_ctrl with TIMEOUT_CYC=100 and ACQ_FRAMES=3.
// Expected counter values follow whether IMU_FRAME_CTRL_STATS_EN is defined for the build.
module tb_imu_frame_ctrl;

`ifdef IMU_FRAME_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         en;
   logic         frame_done;
   logic [120:0] frame_in;
   logic [120:0] out_frame;
   logic         out_valid;
   logic         out_ready;
   logic         link_up;
   logic         link_lost;
   logic [15:0]  frame_cnt;
   logic [15:0]  drop_cnt;

   int checks = 0;
   int errors = 0;
   int exp_frame = 0;
   int exp_drop  = 0;

   imu_frame_ctrl #(.TIMEOUT_CYC(100), .ACQ_FRAMES(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .frame_done (frame_done),
      .frame_in   (frame_in),
      .out_frame  (out_frame),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .link_up    (link_up),
      .link_lost  (link_lost),
      .frame_cnt  (frame_cnt),
      .drop_cnt   (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish expected finish before 500000ns");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [120:0] mk_frame(input logic [7:0] tag);
      return {tag, 8'h5A, 97'd0, tag};
   endfunction

   function automatic logic [15:0] exp_fc();
      return STATS ? 16'(exp_frame) : 16'd0;
   endfunction

   function automatic logic [15:0] exp_dc();
      return STATS ? 16'(exp_drop) : 16'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [120:0] f);
      frame_done = 1'b1;
      frame_in   = f;
      tick();
      frame_done = 1'b0;
   endtask

   task automatic lock_link(input logic [7:0] base);
      send(mk_frame(base));
      repeat (4) tick();
      send(mk_frame(base + 8'd1));
      repeat (4) tick();
      send(mk_frame(base + 8'd2));
      exp_frame++;
      repeat (2) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid: got %0b expected 0", out_valid); end
      checks++; if (out_frame !== 121'd0) begin errors++; $display("[TB] FAIL rst_out_frame: got %h expected 0", out_frame); end
      checks++; if (link_up !== 1'b0) begin errors++; $display("[TB] FAIL rst_link_up: got %0b expected 0", link_up); end
      checks++; if (link_lost !== 1'b0) begin errors++; $display("[TB] FAIL rst_link_lost: got %0b expected 0", link_lost); end
      checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); end
      checks++; if (drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rst_drop_cnt: got %0d expected 0", drop_cnt); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_acquisition();
      out_ready = 1'b1;
      send(mk_frame(8'h01));
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL acq_f1_not_fwd: got %0b expected 0", out_valid); end
      repeat (19) tick();
      send(mk_frame(8'h02));
      checks++; if ({link_up, out_valid} !== 2'b00) begin errors++; $display("[TB] FAIL acq_f2_state: got %b expected 00", {link_up, out_valid}); end
      repeat (19) tick();
      send(mk_frame(8'h03));
      exp_frame++;
      checks++; if (link_up !== 1'b1) begin errors++; $display("[TB] FAIL acq_link_up: got %0b expected 1", link_up); end
      checks++; if (out_valid !== 1'b1 || out_frame !== mk_frame(8'h03)) begin errors++; $display("[TB] FAIL acq_out_frame: got %0b/%h expected 1/%h", out_valid, out_frame, mk_frame(8'h03)); end
      checks++; if (frame_cnt !== exp_fc()) begin errors++; $display("[TB] FAIL acq_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc()); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL acq_drain: got %0b expected 0", out_valid); end
   endtask

   task automatic test_timeout();
      int bad = 0;
      for (int k = 2; k <= 100; k++) begin
         tick();
         if (link_up !== 1'b1 || link_lost !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL to_hold_locked: got %0d bad cycles expected 0", bad); end
      tick();
      checks++; if ({link_up, link_lost} !== 2'b01) begin errors++; $display("[TB] FAIL to_link_lost: got up/lost %b expected 01", {link_up, link_lost}); end
      send(mk_frame(8'h10));
      checks++; if ({link_lost, out_valid, link_up} !== 3'b000) begin errors++; $display("[TB] FAIL to_after_loss: got lost/valid/up %b expected 000", {link_lost, out_valid, link_up}); end
      repeat (4) tick();
      send(mk_frame(8'h11));
      checks++; if (link_up !== 1'b0) begin errors++; $display("[TB] FAIL to_reacq_mid: got %0b expected 0", link_up); end
      repeat (4) tick();
      send(mk_frame(8'h12));
      exp_frame++;
      checks++; if (link_up !== 1'b1 || out_frame !== mk_frame(8'h12)) begin errors++; $display("[TB] FAIL to_relock: got %0b/%h expected 1/%h", link_up, out_frame, mk_frame(8'h12)); end
   endtask

   task automatic test_tie();
      repeat (100) tick();
      frame_done = 1'b1;
      frame_in   = mk_frame(8'h20);
      tick();
      frame_done = 1'b0;
      exp_frame++;
      checks++; if ({link_up, link_lost} !== 2'b10) begin errors++; $display("[TB] FAIL tie_no_loss: got up/lost %b expected 10", {link_up, link_lost}); end
      checks++; if (out_valid !== 1'b1 || out_frame !== mk_frame(8'h20)) begin errors++; $display("[TB] FAIL tie_forward: got %0b/%h expected 1/%h", out_valid, out_frame, mk_frame(8'h20)); end
      checks++; if (frame_cnt !== exp_fc()) begin errors++; $display("[TB] FAIL tie_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc()); end
      repeat (100) tick();
      checks++; if ({link_up, link_lost} !== 2'b10) begin errors++; $display("[TB] FAIL tie_idle_cleared: got up/lost %b expected 10", {link_up, link_lost}); end
      tick();
      checks++; if ({link_up, link_lost} !== 2'b01) begin errors++; $display("[TB] FAIL tie_later_loss: got up/lost %b expected 01", {link_up, link_lost}); end
   endtask

   task automatic test_backpressure();
      int held = 0;
      lock_link(8'h30);
      out_ready = 1'b0;
      send(mk_frame(8'hA0));
      if (out_frame !== mk_frame(8'hA0)) held++;
      send(mk_frame(8'hB0));
      if (out_frame !== mk_frame(8'hA0)) held++;
      send(mk_frame(8'hC0));
      if (out_frame !== mk_frame(8'hA0)) held++;
      send(mk_frame(8'hD0));
      exp_frame += 2;
      exp_drop  += 2;
      checks++; if (held != 0 || out_frame !== mk_frame(8'hA0) || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_head_hold: got %h (%0d misses) expected %h", out_frame, held, mk_frame(8'hA0)); end
      checks++; if (drop_cnt !== exp_dc()) begin errors++; $display("[TB] FAIL bp_drop_cnt: got %0d expected %0d", drop_cnt, exp_dc()); end
      checks++; if (frame_cnt !== exp_fc()) begin errors++; $display("[TB] FAIL bp_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc()); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1 || out_frame !== mk_frame(8'hB0)) begin errors++; $display("[TB] FAIL bp_second: got %0b/%h expected 1/%h", out_valid, out_frame, mk_frame(8'hB0)); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_empty: got %0b expected 0", out_valid); end
   endtask

   task automatic test_full_pop();
      out_ready = 1'b0;
      send(mk_frame(8'hA2));
      send(mk_frame(8'hB2));
      frame_done = 1'b1;
      frame_in   = mk_frame(8'hC2);
      out_ready  = 1'b1;
      tick();
      frame_done = 1'b0;
      exp_frame += 3;
      checks++; if (out_valid !== 1'b1 || out_frame !== mk_frame(8'hB2)) begin errors++; $display("[TB] FAIL fp_head: got %0b/%h expected 1/%h", out_valid, out_frame, mk_frame(8'hB2)); end
      checks++; if (drop_cnt !== exp_dc()) begin errors++; $display("[TB] FAIL fp_drop_cnt: got %0d expected %0d", drop_cnt, exp_dc()); end
      checks++; if (frame_cnt !== exp_fc()) begin errors++; $display("[TB] FAIL fp_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc()); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_frame !== mk_frame(8'hC2)) begin errors++; $display("[TB] FAIL fp_tail: got %0b/%h expected 1/%h", out_valid, out_frame, mk_frame(8'hC2)); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fp_empty: got %0b expected 0", out_valid); end
   endtask

   task automatic test_enable();
      out_ready = 1'b0;
      send(mk_frame(8'hA3));
      exp_frame++;
      en         = 1'b0;
      frame_done = 1'b1;
      frame_in   = mk_frame(8'hEE);
      tick();
      frame_done = 1'b0;
      en         = 1'b1;
      checks++; if ({link_up, link_lost} !== 2'b01) begin errors++; $display("[TB] FAIL en_link_lost: got up/lost %b expected 01", {link_up, link_lost}); end
      checks++; if (out_valid !== 1'b1 || out_frame !== mk_frame(8'hA3)) begin errors++; $display("[TB] FAIL en_buffer_kept: got %0b/%h expected 1/%h", out_valid, out_frame, mk_frame(8'hA3)); end
      checks++; if (frame_cnt !== exp_fc()) begin errors++; $display("[TB] FAIL en_no_push: got %0d expected %0d", frame_cnt, exp_fc()); end
      out_ready = 1'b1;
      tick();
      checks++; if ({out_valid, link_lost} !== 2'b00) begin errors++; $display("[TB] FAIL en_drain: got valid/lost %b expected 00", {out_valid, link_lost}); end
      send(mk_frame(8'h41));
      repeat (4) tick();
      send(mk_frame(8'h42));
      checks++; if ({link_up, out_valid} !== 2'b00) begin errors++; $display("[TB] FAIL en_reacq_two: got up/valid %b expected 00", {link_up, out_valid}); end
      repeat (4) tick();
      send(mk_frame(8'h43));
      exp_frame++;
      checks++; if (link_up !== 1'b1 || out_frame !== mk_frame(8'h43)) begin errors++; $display("[TB] FAIL en_relock: got %0b/%h expected 1/%h", link_up, out_frame, mk_frame(8'h43)); end
      checks++; if (frame_cnt !== exp_fc()) begin errors++; $display("[TB] FAIL en_frame_cnt: got %0d expected %0d", frame_cnt, exp_fc()); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      send(mk_frame(8'h51));
      send(mk_frame(8'h52));
      checks++; if (out_valid !== 1'b1 || link_up !== 1'b1) begin errors++; $display("[TB] FAIL rm_pre: got valid/up %b expected 11", {out_valid, link_up}); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_frame = 0;
      exp_drop  = 0;
      checks++; if ({out_valid, link_up, link_lost} !== 3'b000 || out_frame !== 121'd0) begin errors++; $display("[TB] FAIL rm_outputs: got valid/up/lost %b frame %h expected 000 frame 0", {out_valid, link_up, link_lost}, out_frame); end
      checks++; if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rm_counters: got %0d/%0d expected 0/0", frame_cnt, drop_cnt); end
      send(mk_frame(8'h53));
      checks++; if ({out_valid, link_up} !== 2'b00) begin errors++; $display("[TB] FAIL rm_no_link_after: got valid/up %b expected 00", {out_valid, link_up}); end
   endtask

   initial begin
      rst        = 1'b1;
      en         = 1'b1;
      frame_done = 1'b0;
      frame_in   = '0;
      out_ready  = 1'b1;
      test_reset();
      test_acquisition();
      test_timeout();
      test_tie();
      test_backpressure();
      test_full_pop();
      test_enable();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imu_frame_ctrl.md
# imu_frame_ctrl

Link supervisor and frame scheduler between the CSV frame parser and downstream consumers of sensor frames. It watches parser `frame_done` pulses and runs a link state machine with an acquisition phase and a timeout watchdog. Frames are forwarded only while the link is locked, through a 2-entry buffer with a valid/ready handshake. Frames that arrive while the buffer is full are dropped and counted.

## Interface
- `TIMEOUT_CYC`, default 5_000_000: idle cycles without `frame_done` that count as link loss (100 ms at 50 MHz).
- `ACQ_FRAMES`, default 3: consecutive in-time frames required to lock. Legal range ≥1.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: block enable. Low forces NO_LINK and ignores frames.
- `frame_done` in 1: one-cycle pulse from parser; `frame_in` is valid in the same cycle.
- `frame_in` in 121: packed frame. ax1[120:105], ay1[104:89], az1[88:73], ax2[72:57], ay2[56:41], az2[40:25], jx[24:13], jy[12:1], btn[0].
- `out_frame` out 121: buffer head, same packing.
- `out_valid` out 1: buffer non-empty.
- `out_ready` in 1: consumer accepts the head when `out_valid && out_ready`.
- `link_up` out 1: state == LOCKED.
- `link_lost` out 1: one-cycle pulse on LOCKED→NO_LINK.
- `frame_cnt` out 16: frames pushed into the buffer. Saturates at 0xFFFF.
- `drop_cnt` out 16: frames discarded because the buffer was full. Saturates at 0xFFFF.

## Operation
- Idle counter `idle` (width ⌈log2(TIMEOUT_CYC+1)⌉):
  - Cleared on `frame_done`; otherwise increments, saturating at TIMEOUT_CYC.
  - Timeout event is `idle == TIMEOUT_CYC && !frame_done`. When both occur in the same cycle, `frame_done` wins.
- States:
  - **NO_LINK** (reset state). On `frame_done`, go to ACQUIRE with acq=1, or straight to LOCKED if ACQ_FRAMES==1.
  - **ACQUIRE**. On `frame_done`, acq++. On reaching ACQ_FRAMES, go to LOCKED. On timeout, go to NO_LINK with acq=0.
  - **LOCKED**. On timeout, go to NO_LINK and pulse `link_lost`.
- Forwarding:
  - A frame is forwarded if it arrives in LOCKED, or if it is the frame that completes acquisition. Frames in NO_LINK or in ACQUIRE before lock are consumed silently and are not counted.
- Buffer (2-entry FIFO, registered outputs):
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - Full with no pop: the frame is discarded and `drop_cnt` increments.
  - Pop on `out_valid && out_ready`.
  - Simultaneous push and pop when empty is not possible, because `out_valid` is low while empty.
- Link loss does not flush the buffer. Buffered frames still drain.
- `en` low:
  - State goes to NO_LINK next cycle and acq clears.
  - `idle` holds at 0.
  - No push occurs. The buffer still drains.
  - `link_lost` pulses if the state was LOCKED.
- Counters are never cleared except by `rst`.

## Timing
- Reset values: `out_valid`=0, `out_frame`=0, `link_up`=0, `link_lost`=0, `frame_cnt`=0, `drop_cnt`=0, state NO_LINK, `idle`=0, buffer empty.
- Reset during operation discards buffer contents on the next edge.
- Push latency: `frame_done` at cycle t with the buffer empty gives `out_valid`=1 and `out_frame`=`frame_in` at t+1.
- Pop at cycle t: the second entry (if any) appears at t+1; otherwise `out_valid`=0 at t+1.
- `link_up` rises at t+1 after the locking `frame_done` at t. It falls at t+1 after the timeout cycle t, together with the `link_lost` pulse.
- `frame_cnt` and `drop_cnt` update at t+1 after the push or drop cycle.

## Configuration
- `IMU_FRAME_CTRL_STATS_EN` defined: `frame_cnt` and `drop_cnt` are implemented as specified.
- Not defined: both ports are tied to 0 and the counter logic is omitted. Drop behaviour is unchanged.

## Test plan
All scenarios use TIMEOUT_CYC=100 and ACQ_FRAMES=3.
- Acquisition: three `frame_done` pulses 20 cycles apart, `out_ready`=1.
  - `link_up` rises 1 cycle after the 3rd pulse.
  - Only the 3rd frame appears on `out_frame`.
  - `frame_cnt`=1.
- Timeout: once LOCKED, no frames for 101 cycles.
  - `link_lost` pulses once and `link_up` drops.
  - A frame 1 cycle later is not forwarded, and the state goes to ACQUIRE.
- Tie: `frame_done` arrives exactly in the cycle where `idle`==100 in LOCKED.
  - No `link_lost`; the frame is forwarded; `idle` resets to 0.
- Backpressure: LOCKED, `out_ready`=0, frames A, B, C, D pushed.
  - `out_frame`=A throughout.
  - `drop_cnt`=2 and `frame_cnt`=2.
  - After raising `out_ready`, A then B are delivered and `out_valid` falls.
- Full with simultaneous pop: buffer holds A, B; `frame_done`(C) and `out_ready`=1 in the same cycle.
  - Next cycle the buffer holds B, C.
  - `drop_cnt` is unchanged.
- Enable and reset:
  - With buffer holding A and LOCKED, drop `en` for 1 cycle: `link_lost` pulses, A still drains, and a new lock needs 3 fresh frames.
  - `rst` mid-stream clears all outputs to their reset values.
